// File: rtl/bcd_7seg_scan_driver.sv
// bcd_7seg_scan_driver
// Time-multiplexed common-anode 7-segment driver for a packed BCD word.
// A captured word is copied into the displayed register only when digit 0's
// drive slot begins, so a frame always shows one consistent value. Each digit
// slot is preceded by a dark gap so adjacent anodes never overlap (ghosting).
module bcd_7seg_scan_driver #(
  parameter int DIGITS         = 2,
  parameter int REFRESH_CYCLES = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int LZB            = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   i_bcd,
  input  logic                  i_dv,
  input  logic                  i_en,
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_loaded,
  output logic                  o_frame
);

  localparam int CNT_MAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;
  localparam logic [6:0]       SEG_DASH = 7'h3F;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic [4*DIGITS-1:0]   r_shadow;
  logic [4*DIGITS-1:0]   r_active;
  logic                  r_valid;
  logic                  r_loaded;
  logic [6:0]            r_seg;
  logic [DIGITS-1:0]     r_an;
  logic                  r_frame;

  logic [4*DIGITS-1:0]   w_drv_word;
  logic                  w_drv_blank;
  logic [6:0]            w_drv_seg;
  logic [DIGITS-1:0]     w_drv_an;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  // A digit above position 0 is a leading zero when it and every higher nibble are zero.
  function automatic logic f_blanked(input logic [4*DIGITS-1:0] word,
                                     input logic [IDX_W-1:0]    idx);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (k >= int'(idx)) begin
        upper_zero = upper_zero & (word[4*k +: 4] == 4'd0);
      end
    end
    return (LZB != 0) && (idx != '0) && upper_zero;
  endfunction

  // Pattern for the slot about to be entered; digit 0 uses the shadow since active loads on that edge.
  always_comb begin
    w_drv_word  = (r_idx == '0) ? r_shadow : r_active;
    w_drv_blank = f_blanked(w_drv_word, r_idx);
    w_drv_seg   = w_drv_blank ? SEG_OFF : f_decode(w_drv_word[4*r_idx +: 4]);
    w_drv_an    = w_drv_blank ? '1 : ~(DIGITS'(1) << r_idx);
  end

  // Capture path: last strobe wins, valid latches forever, loaded echoes the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_valid  <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_loaded <= i_dv;
      if (i_dv) begin
        r_shadow <= i_bcd;
        r_valid  <= 1'b1;
      end
    end
  end

  // Scan FSM with registered anode/segment/frame outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_OFF;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_active <= '0;
      r_seg    <= SEG_OFF;
      r_an     <= '1;
      r_frame  <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      if (!i_en) begin
        r_state <= S_OFF;
        r_idx   <= '0;
        r_cnt   <= '0;
        r_seg   <= SEG_OFF;
        r_an    <= '1;
      end else begin
        case (r_state)
          S_OFF: begin
            if (r_valid) begin
              r_state <= S_BLANK;
              r_idx   <= '0;
              r_cnt   <= '0;
            end
          end
          S_BLANK: begin
            if (r_cnt == BLK_LAST) begin
              r_state <= S_DRIVE;
              r_cnt   <= '0;
              r_seg   <= w_drv_seg;
              r_an    <= w_drv_an;
              if (r_idx == '0) begin
                r_active <= r_shadow;
                r_frame  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_DRIVE: begin
            if (r_cnt == REF_LAST) begin
              r_state <= S_BLANK;
              r_cnt   <= '0;
              r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
              r_seg   <= SEG_OFF;
              r_an    <= '1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= S_OFF;
            r_seg   <= SEG_OFF;
            r_an    <= '1;
          end
        endcase
      end
    end
  end

  assign o_seg    = r_seg;
  assign o_an     = r_an;
  assign o_loaded = r_loaded;
  assign o_frame  = r_frame;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Testbench for bcd_7seg_scan_driver: two instances (leading-zero blanking on
// and off) share stimulus and are compared every cycle against a frame-timeline
// reference model.
module tb_bcd_7seg_scan_driver;

  localparam int D     = 2;
  localparam int R     = 4;
  localparam int B     = 1;
  localparam int SLOT  = B + R;
  localparam int FRAME = D * SLOT;

  localparam logic [6:0] DEC [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic       clk;
  logic       rst_n;
  logic [7:0] i_bcd;
  logic       i_dv;
  logic       i_en;

  logic [6:0] seg_a,    seg_b;
  logic [1:0] an_a,     an_b;
  logic       loaded_a, loaded_b;
  logic       frame_a,  frame_b;

  int n_checks;
  int n_fail;

  bcd_7seg_scan_driver #(.DIGITS(D), .REFRESH_CYCLES(R), .BLANK_CYCLES(B), .LZB(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_bcd(i_bcd), .i_dv(i_dv), .i_en(i_en),
    .o_seg(seg_a), .o_an(an_a), .o_loaded(loaded_a), .o_frame(frame_a)
  );

  bcd_7seg_scan_driver #(.DIGITS(D), .REFRESH_CYCLES(R), .BLANK_CYCLES(B), .LZB(0)) u_dut_nolzb (
    .clk(clk), .rst_n(rst_n), .i_bcd(i_bcd), .i_dv(i_dv), .i_en(i_en),
    .o_seg(seg_b), .o_an(an_b), .o_loaded(loaded_b), .o_frame(frame_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position on the frame timeline since leaving the dark/off condition.
  bit         m_run;
  int         m_t;
  int         m_pos;
  int         m_dig;
  bit         m_valid;
  logic [7:0] m_shadow;
  logic [7:0] m_active;
  logic [6:0] e_seg [2];
  logic [1:0] e_an  [2];
  logic       e_loaded;
  logic       e_frame;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run    = 1'b0;
      m_t      = 0;
      m_valid  = 1'b0;
      m_shadow = 8'h00;
      m_active = 8'h00;
      e_loaded = 1'b0;
      e_frame  = 1'b0;
      for (int l = 0; l < 2; l++) begin
        e_seg[l] = 7'h7F;
        e_an[l]  = 2'b11;
      end
    end else begin
      e_frame = 1'b0;
      for (int l = 0; l < 2; l++) begin
        e_seg[l] = 7'h7F;
        e_an[l]  = 2'b11;
      end
      if (!i_en) begin
        m_run = 1'b0;
      end else if (!m_run) begin
        if (m_valid) begin
          m_run = 1'b1;
          m_t   = 0;
        end
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
      if (m_run) begin
        m_pos = m_t % SLOT;
        m_dig = m_t / SLOT;
        if (m_pos >= B) begin
          if (m_pos == B && m_dig == 0) begin
            m_active = m_shadow;
            e_frame  = 1'b1;
          end
          for (int l = 0; l < 2; l++) begin
            int upper;
            int nib;
            upper = int'(m_active) >> (4 * m_dig);
            nib   = upper & 15;
            if (!(l == 0 && m_dig > 0 && upper == 0)) begin
              e_seg[l] = (nib > 9) ? 7'h3F : DEC[nib];
              e_an[l]  = 2'(3 ^ (1 << m_dig));
            end
          end
        end
      end
      e_loaded = i_dv;
      if (i_dv) begin
        m_shadow = i_bcd;
        m_valid  = 1'b1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle();
    check_eq("seg_lzb",      32'(seg_a),    32'(e_seg[0]));
    check_eq("an_lzb",       32'(an_a),     32'(e_an[0]));
    check_eq("loaded_lzb",   32'(loaded_a), 32'(e_loaded));
    check_eq("frame_lzb",    32'(frame_a),  32'(e_frame));
    check_eq("seg_nolzb",    32'(seg_b),    32'(e_seg[1]));
    check_eq("an_nolzb",     32'(an_b),     32'(e_an[1]));
    check_eq("loaded_nolzb", 32'(loaded_b), 32'(e_loaded));
    check_eq("frame_nolzb",  32'(frame_b),  32'(e_frame));
  endtask

  // Apply inputs for the next rising edge, then compare at the following falling edge.
  task automatic step(input logic dv, input logic [7:0] bcd, input logic en);
    i_dv  = dv;
    i_bcd = bcd;
    i_en  = en;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b1);
  endtask

  function automatic logic [7:0] rand_bcd();
    logic [7:0] v;
    v = 8'($urandom);
    if ($urandom_range(0, 2) == 0) v[7:4] = 4'h0;
    if ($urandom_range(0, 5) == 0) v[3:0] = 4'h0;
    return v;
  endfunction

  // Advance until the model shows a digit being driven; a missed bound is a failure.
  task automatic wait_drive(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      if (e_an[1] != 2'b11) found = 1'b1;
      else run(1);
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, "_seg_lzb"},   32'(seg_a),    32'h7F);
    check_eq({tag, "_an_lzb"},    32'(an_a),     32'h3);
    check_eq({tag, "_seg_nolzb"}, 32'(seg_b),    32'h7F);
    check_eq({tag, "_an_nolzb"},  32'(an_b),     32'h3);
    check_eq({tag, "_loaded"},    32'(loaded_a), 32'h0);
    check_eq({tag, "_frame"},     32'(frame_a),  32'h0);
  endtask

  initial begin
    bit found;
    n_checks = 0;
    n_fail   = 0;
    i_dv     = 1'b0;
    i_bcd    = 8'h00;
    i_en     = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_dark("reset_async");
    #10 rst_n = 1'b1;

    // Idle with enable but nothing captured: stays dark.
    for (int i = 0; i < 100; i++) step(1'b0, 8'h00, 1'b1);

    // Basic two-digit display.
    step(1'b1, 8'h42, 1'b1);
    run(3 * FRAME);

    // Leading zeros, all zero, invalid nibble.
    step(1'b1, 8'h07, 1'b1);
    run(2 * FRAME + 2);
    step(1'b1, 8'h00, 1'b1);
    run(2 * FRAME + 2);
    step(1'b1, 8'hA3, 1'b1);
    run(2 * FRAME + 2);
    step(1'b1, 8'h42, 1'b1);
    run(2 * FRAME + 2);

    // Capture on the very edge that enters digit 0's drive slot.
    found = 1'b0;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      if (m_run && m_t == B - 1) found = 1'b1;
      else run(1);
    end
    check_eq("sync_edge_found", 32'(found), 32'd1);
    step(1'b1, 8'h55, 1'b1);
    run(2 * FRAME + 2);

    // Two captures within one frame: only the last is shown.
    step(1'b1, 8'h11, 1'b1);
    run(2);
    step(1'b1, 8'h99, 1'b1);
    run(2 * FRAME + 2);

    // Enable dropped mid-drive, then restored.
    wait_drive("en_drive_found");
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0);
    run(2 * FRAME + 2);

    // Asynchronous reset in the middle of a drive slot.
    wait_drive("rst_drive_found");
    #2 rst_n = 1'b0;
    #1 check_dark("reset_mid_drive");
    @(negedge clk);
    check_cycle();
    #2 rst_n = 1'b1;
    run(10);

    // Randomized traffic: captures, enable toggles, arbitrary nibbles.
    for (int i = 0; i < 2500; i++) begin
      logic dv;
      logic en;
      dv = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 39) != 0);
      step(dv, rand_bcd(), en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
